// File: rtl/cpu_step_ctrl.sv
// Step/run controller: turns debounced button pulses into a one-cycle CPU
// clock-enable, with single-step, divided free-run and stop-on-halt modes,
// and counts every enable it issues.
module cpu_step_ctrl #(
    parameter int unsigned RUN_DIV = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_ped,
    input  logic             run_ped,
    input  logic             halt_req,
    output logic             cpu_en,
    output logic             running,
    output logic             halted,
    output logic [CNT_W-1:0] cyc_cnt
);

    // Divider needs at least one bit even when RUN_DIV is 1
    localparam int unsigned      DIV_W    = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_STEP = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_STOP = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] cnt_q;

    // Moore outputs decoded purely from registered state
    always_comb begin
        cpu_en  = (state_q == S_STEP) || ((state_q == S_RUN) && (div_q == DIV_LAST));
        running = (state_q == S_RUN);
        halted  = (state_q == S_STOP);
        cyc_cnt = cnt_q;
    end

    // Next-state selection; halt is only honoured in a cycle that issues an enable
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (run_ped) begin
                    state_d = S_RUN;
                end else if (step_ped) begin
                    state_d = S_STEP;
                end
            end
            S_STEP: begin
                state_d = halt_req ? S_STOP : S_IDLE;
            end
            S_RUN: begin
                if (cpu_en && halt_req) begin
                    state_d = S_STOP;
                end else if (run_ped) begin
                    state_d = S_IDLE;
                end
            end
            S_STOP: begin
                if (run_ped) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Divider advances only while staying in RUN, so every RUN entry starts at 0
    always_comb begin
        div_d = '0;
        if ((state_q == S_RUN) && (state_d == S_RUN)) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        end
    end

    // State, divider and enable counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            if (cpu_en) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Scoreboard bench for cpu_step_ctrl: a driver advances a behavioural model
// each cycle and queues the expected outputs; a monitor compares them.
module tb_cpu_step_ctrl;

    localparam int unsigned RUN_DIV = 4;
    localparam int unsigned CNT_W   = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             step_ped = 1'b0;
    logic             run_ped = 1'b0;
    logic             halt_req = 1'b0;
    logic             cpu_en;
    logic             running;
    logic             halted;
    logic [CNT_W-1:0] cyc_cnt;

    cpu_step_ctrl #(
        .RUN_DIV(RUN_DIV),
        .CNT_W  (CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .step_ped(step_ped),
        .run_ped (run_ped),
        .halt_req(halt_req),
        .cpu_en  (cpu_en),
        .running (running),
        .halted  (halted),
        .cyc_cnt (cyc_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int en;
        int run;
        int hlt;
        int cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   mon_en   = 1'b0;

    // Reference model, in terms of operator-visible behaviour
    bit m_step_pending;   // a single-step enable is due this cycle
    bit m_running;
    bit m_halted;
    int m_run_age;        // cycles spent in run mode so far (0 = first cycle)
    int m_count;          // total enables issued

    function automatic int m_en_now();
        if (m_step_pending) return 1;
        if (m_running && ((m_run_age + 1) % RUN_DIV == 0)) return 1;
        return 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_step_pending = 0;
        m_running      = 0;
        m_halted       = 0;
        m_run_age      = 0;
        m_count        = 0;
    endtask

    // Advance the model across one clock edge given this cycle's inputs
    task automatic model_edge(input bit s, input bit r, input bit h);
        int en;
        en = m_en_now();
        m_count = m_count + en;
        if (m_step_pending) begin
            m_step_pending = 0;
            m_halted       = h;
        end else if (m_running) begin
            if (en == 1 && h) begin
                m_running = 0;
                m_halted  = 1;
            end else if (r) begin
                m_running = 0;
            end else begin
                m_run_age++;
            end
        end else if (m_halted) begin
            if (r) m_halted = 0;
        end else begin
            if (r) begin
                m_running = 1;
                m_run_age = 0;
            end else if (s) begin
                m_step_pending = 1;
            end
        end
    endtask

    task automatic push_expected();
        exp_t e;
        e.en  = m_en_now();
        e.run = m_running;
        e.hlt = m_halted;
        e.cnt = m_count % (1 << CNT_W);
        exp_q.push_back(e);
    endtask

    // One clock cycle with the given inputs
    task automatic cycle(input bit s, input bit r, input bit h);
        step_ped = s;
        run_ped  = r;
        halt_req = h;
        @(posedge clk);
        model_edge(s, r, h);
        push_expected();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once
    task automatic do_reset();
        mon_en = 1'b0;
        exp_q.delete();
        step_ped = 1'b0;
        run_ped  = 1'b0;
        halt_req = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        chk("rst_cpu_en", cpu_en, 0);
        chk("rst_running", running, 0);
        chk("rst_halted", halted, 0);
        chk("rst_cyc_cnt", cyc_cnt, 0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        mon_en = 1'b1;
    endtask

    // Monitor: compare the DUT against the oldest queued expectation
    always @(negedge clk) begin
        if (mon_en && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("cpu_en", cpu_en, e.en);
            chk("running", running, e.run);
            chk("halted", halted, e.hlt);
            chk("cyc_cnt", cyc_cnt, e.cnt);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // Single step from idle
        idle(8);
        cycle(1'b1, 1'b0, 1'b0);
        idle(4);

        // Free run for three enables, then stop with run_ped
        cycle(1'b0, 1'b1, 1'b0);
        idle(12);
        cycle(1'b0, 1'b1, 1'b0);
        idle(4);

        // Halt on the second run enable; step ignored while stopped, run acknowledges
        cycle(1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 10; i++) cycle(1'b0, 1'b0, i >= 5);
        cycle(1'b1, 1'b0, 1'b1);
        idle(3);
        cycle(1'b0, 1'b1, 1'b0);
        idle(3);

        // Step with halt set: stops after the single enable
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        idle(2);
        cycle(1'b0, 1'b1, 1'b0);
        idle(2);

        // Run and step together: run wins; pulse during step is dropped
        cycle(1'b1, 1'b1, 1'b0);
        idle(6);
        cycle(1'b0, 1'b1, 1'b0);
        idle(2);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        idle(3);

        // Seventeen steps from reset wrap the 4-bit counter to 1
        do_reset();
        for (int i = 0; i < 17; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            cycle(1'b0, 1'b0, 1'b0);
        end
        idle(2);

        // Reset mid-run, then no enables until a new pulse
        cycle(1'b0, 1'b1, 1'b0);
        idle(5);
        do_reset();
        idle(10);

        // Randomised traffic with occasional resets
        for (int i = 0; i < 700; i++) begin
            bit s, r, h;
            s = ($urandom_range(0, 7) == 0);
            r = ($urandom_range(0, 15) == 0);
            h = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 299) == 0) do_reset();
            cycle(s, r, h);
        end
        idle(2);

        @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
